ws2812_hsv_frame_sched: RTL
===========================

Name: ws2812_hsv_frame_sched

Overview:
Sequences one shared HSV-to-RGB converter instance to produce a full WS2812 strip frame. On each frame request it walks LED indices 0..LED_NUM-1 and computes a per-LED hue. It drives the converter, waits out the converter latency, captures the RGB result, and hands each pixel to the downstream WS2812 serializer over a valid/ready handshake in GRB order. It advances a base hue per frame for rainbow/scroll animation.

Parameters:
LED_NUM, 64, number of LEDs per frame (>=1)
HSV_DEPTH, 8, width of hue/sat/val driven to converter
RGB_DEPTH, 8, width of each converter colour output
CONV_LAT, 1, cycles from converter input stable to RGB output valid (>=1)
IDX_W, $clog2(LED_NUM) (min 1), LED index width

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  frame request pulse
hue_step  in  HSV_DEPTH  hue increment between adjacent LEDs
speed  in  HSV_DEPTH  base-hue increment applied after each frame
sat_cfg  in  HSV_DEPTH  saturation for all LEDs of a frame
val_cfg  in  HSV_DEPTH  value/brightness for all LEDs of a frame
hsv_hue  out  HSV_DEPTH  to converter hue
hsv_sat  out  HSV_DEPTH  to converter sat
hsv_val  out  HSV_DEPTH  to converter val
rgb_r  in  RGB_DEPTH  from converter R
rgb_g  in  RGB_DEPTH  from converter G
rgb_b  in  RGB_DEPTH  from converter B
pix_valid  out  1  pixel available
pix_ready  in  1  serializer accepts pixel
pix_data  out  3*RGB_DEPTH  {G,R,B}
pix_idx  out  IDX_W  LED index of pix_data
pix_last  out  1  pix_data is LED_NUM-1
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last pixel accepted
base_hue  out  HSV_DEPTH  current frame base hue

Behaviour:
- Reset (async, rstn=0): state IDLE. All outputs 0: hsv_*, pix_*, busy, frame_done, base_hue. Pending flag and counters cleared. Reset mid-frame aborts immediately; no partial-frame resume.
- States: IDLE, ISSUE, WAIT, OUT, DONE.
- IDLE: on start=1 (or pending=1), latch sat_cfg/val_cfg/hue_step into shadow regs and set cur_hue=base_hue, idx=0, busy=1, then -> ISSUE. Config changes mid-frame have no effect until the next frame.
- ISSUE (1 cycle): hsv_hue=cur_hue, hsv_sat/val=shadow values. All hsv_* are registered and held stable through WAIT. -> WAIT.
- WAIT (CONV_LAT cycles, down-counter): at the end of the last WAIT cycle capture pix_data={rgb_g,rgb_r,rgb_b}, pix_idx=idx, pix_last=(idx==LED_NUM-1), pix_valid=1. -> OUT.
- OUT: pix_valid and pix_data/idx/last held stable until pix_ready=1 (AXI-style; pix_valid never drops without acceptance). On acceptance, pix_valid=0 in the next cycle.
  - If not last: idx+1, cur_hue=cur_hue+hue_step mod 2^HSV_DEPTH -> ISSUE.
  - If last: -> DONE.
- DONE (1 cycle): frame_done=1, busy=0, base_hue=base_hue+speed mod 2^HSV_DEPTH. -> IDLE.
- Minimum throughput: 2+CONV_LAT cycles per pixel with pix_ready tied high.
- start while busy (ISSUE/WAIT/OUT/DONE): sets a 1-deep pending flag; further starts do not stack. IDLE consumes pending the cycle after DONE and clears it. start in the same cycle as DONE also sets pending.
- Hue wrap: all hue additions are modulo 2^HSV_DEPTH with no saturation.
- LED_NUM=1: the first pixel has pix_last=1.

Test Plan:
- Reset: assert rstn=0 mid-OUT with pix_valid=1 -> all outputs 0 immediately; after release, state IDLE and no pixels emitted without start.
- Basic frame: LED_NUM=4, base 0, hue_step=64, sat=255, val=128, pix_ready=1, converter stub (CONV_LAT=1) -> hsv_hue sequence 0,64,128,192; 4 pixels with idx 0..3 and pix_data={G,R,B} from the stub; pix_last only on idx 3; frame_done one pulse; 12-cycle pixel span.
- Backpressure: hold pix_ready=0 for 5 cycles on idx 1 -> pix_valid/pix_data stable all 5 cycles; hsv_hue not advanced; idx 2 issued only after acceptance.
- Wrap and speed: hue_step=100, speed=200, two frames -> frame1 hues 0,100,200,44; base_hue=200 after frame1; frame2 hues 200,44,144,244.
- Config shadowing: change val_cfg 255->10 during pixel 2 -> hsv_val stays 255 for the rest of the frame and becomes 10 on the next frame.
- Start collisions: pulse start 3 times during a frame -> exactly one further frame runs, starting immediately after DONE; start coincident with DONE -> that frame also runs.

Source files
------------

// File: rtl/ws2812_hsv_frame_sched_if.sv
// Pixel stream from the frame scheduler to the WS2812 serializer.
// The payload is held stable while pix_valid is high and pix_ready is low.
interface ws2812_hsv_frame_sched_if #(
    parameter int RGB_DEPTH = 8,
    parameter int IDX_W     = 6
);
    logic                   pix_valid;
    logic                   pix_ready;
    logic [3*RGB_DEPTH-1:0] pix_data;   // {G,R,B}
    logic [IDX_W-1:0]       pix_idx;
    logic                   pix_last;

    modport master (
        output pix_valid, pix_data, pix_idx, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_data, pix_idx, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/ws2812_hsv_frame_sched.sv
// Time-shares one HSV->RGB converter across a WS2812 strip: walks the LEDs,
// computes per-LED hue, captures the converter result and streams GRB pixels.
module ws2812_hsv_frame_sched #(
    parameter  int LED_NUM   = 64,
    parameter  int HSV_DEPTH = 8,
    parameter  int RGB_DEPTH = 8,
    parameter  int CONV_LAT  = 1,
    localparam int IDX_W     = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [HSV_DEPTH-1:0] hue_step,
    input  logic [HSV_DEPTH-1:0] speed,
    input  logic [HSV_DEPTH-1:0] sat_cfg,
    input  logic [HSV_DEPTH-1:0] val_cfg,
    output logic [HSV_DEPTH-1:0] hsv_hue,
    output logic [HSV_DEPTH-1:0] hsv_sat,
    output logic [HSV_DEPTH-1:0] hsv_val,
    input  logic [RGB_DEPTH-1:0] rgb_r,
    input  logic [RGB_DEPTH-1:0] rgb_g,
    input  logic [RGB_DEPTH-1:0] rgb_b,
    ws2812_hsv_frame_sched_if.master pix,
    output logic                 busy,
    output logic                 frame_done,
    output logic [HSV_DEPTH-1:0] base_hue
);
    localparam int               CNT_W    = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LED_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t               state;
    logic                 pending;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     wait_cnt;
    logic [HSV_DEPTH-1:0] cur_hue;
    logic [HSV_DEPTH-1:0] sh_step;
    logic [HSV_DEPTH-1:0] sh_sat;
    logic [HSV_DEPTH-1:0] sh_val;

    // NOTE: every register here is a plain flop (no memory arrays), so all of
    // them are cleared by the async reset; a mid-frame reset leaves nothing to resume.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            pending       <= 1'b0;
            idx           <= '0;
            wait_cnt      <= '0;
            cur_hue       <= '0;
            sh_step       <= '0;
            sh_sat        <= '0;
            sh_val        <= '0;
            hsv_hue       <= '0;
            hsv_sat       <= '0;
            hsv_val       <= '0;
            pix.pix_valid <= 1'b0;
            pix.pix_data  <= '0;
            pix.pix_idx   <= '0;
            pix.pix_last  <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            base_hue      <= '0;
        end else begin
            // NOTE: non-blocking default; only the OUT->DONE transition
            // overrides it, which makes frame_done a registered 1-cycle pulse.
            frame_done <= 1'b0;

            // Requests arriving while a frame runs collapse into one pending frame.
            if (start && state != S_IDLE) pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start || pending) begin
                        sh_step <= hue_step;
                        sh_sat  <= sat_cfg;
                        sh_val  <= val_cfg;
                        cur_hue <= base_hue;
                        idx     <= '0;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    hsv_hue  <= cur_hue;
                    hsv_sat  <= sh_sat;
                    hsv_val  <= sh_val;
                    wait_cnt <= CNT_W'(CONV_LAT - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        pix.pix_data  <= {rgb_g, rgb_r, rgb_b};
                        pix.pix_idx   <= idx;
                        pix.pix_last  <= (idx == LAST_IDX);
                        pix.pix_valid <= 1'b1;
                        state         <= S_OUT;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_OUT: begin
                    if (pix.pix_ready) begin
                        pix.pix_valid <= 1'b0;
                        if (pix.pix_last) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            base_hue   <= base_hue + speed;
                            state      <= S_DONE;
                        end else begin
                            idx     <= idx + 1'b1;
                            cur_hue <= cur_hue + sh_step;
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
